tm1638_frame_seq: RTL and testbench
===================================

Name: tm1638_frame_seq

Overview:
- Upstream command sequencer for spi_fifo: turns a parallel display image (8 digits, 8 LEDs, brightness) into the TM1638 word stream pushed into spi_fifo's 18-bit FIFO port.
- Consumes spi_fifo's read-back bytes and assembles the 8-key scan result.
- Repeats one refresh frame every REFRESH_CYCLES idle clocks while enabled.

Parameters:
- REFRESH_CYCLES, 1000: idle clocks between end of one frame and start of next (>=1).
- KEY_SCAN, 1: 1 = append key-read transaction to each frame; 0 = write-only frame.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Enable  in  1  frame generation enable; sampled only in IDLE.
- i_Segs  in  64  digit segment bytes; digit k = i_Segs[8k+7:8k].
- i_Leds  in  8  LED k = i_Leds[k].
- i_Bright  in  3  brightness 0..7.
- i_Disp_On  in  1  display on/off.
- i_FIFO_Full  in  1  spi_fifo o_FIFO_Full.
- o_Data_Valid  out  1  push strobe to spi_fifo i_Data_Valid.
- o_Data  out  18  word to spi_fifo i_Data.
- i_Rd_Valid  in  1  spi_fifo o_Data_Valid (read byte returned).
- i_Rd_Data  in  8  spi_fifo o_Data.
- o_Keys  out  8  last complete key scan, bit k = key k pressed.
- o_Keys_Valid  out  1  one-cycle pulse when o_Keys updated.
- o_Busy  out  1  high from frame start until last word pushed (and, if KEY_SCAN, all 4 read bytes received).

Behaviour:
- Word format: [17] = read (1: clock in SPI_READ_WIDTH bits, send nothing); [16] = last (raise STB after this byte); [15:8] = 0; [7:0] = byte.
- Push rule: o_Data_Valid is registered, high for exactly one cycle per word. It is asserted only if i_FIFO_Full was 0 in the preceding cycle, and it is never high in two consecutive cycles. The word is accepted whenever o_Data_Valid=1; o_Data is held stable while Valid is high.
- Frame contents (24 words with KEY_SCAN=1, 19 without):
  - W0 0x40, last=1.
  - W1 0xC0, last=0.
  - W2..W17: for k=0..7, byte i_Segs digit k, then {7'b0, i_Leds[k]}. Last=1 on W17 only.
  - W18 {5'b10001, i_Bright} if i_Disp_On, else 0x80; last=1.
  - KEY_SCAN only: W19 0x42, last=0. W20..W23: read=1, byte 0x00, last=1 on W23 only.
- Snapshot: i_Segs, i_Leds, i_Bright and i_Disp_On are captured into internal registers on the IDLE->CMD transition. Input changes mid-frame do not affect the frame in flight.
- States and transitions:
  - IDLE: go to CMD when i_Enable=1 and the gap counter is 0.
  - CMD -> ADDR -> DATA (16 words, 4-bit index) -> CTRL.
  - CTRL -> KEYCMD if KEY_SCAN, else GAP.
  - KEYCMD -> KEYRD (4 pushes) -> WAITRD.
  - WAITRD -> GAP once 4 read bytes have been counted.
  - GAP: load counter with REFRESH_CYCLES, decrement to 0, then IDLE.
- Read assembly: 2-bit byte counter advances on each i_Rd_Valid pulse. For byte b (0..3): o_Keys[b] <= i_Rd_Data[0] and o_Keys[b+4] <= i_Rd_Data[4], staged in a shadow register. On the 4th byte, the shadow is copied to o_Keys and o_Keys_Valid pulses the next cycle. i_Rd_Valid outside WAITRD/KEYRD is ignored.
- i_Enable deassert mid-frame: the frame completes; stop at IDLE.
- FIFO full: stall in the current state with the word held and Valid low; resume on the second cycle after Full drops.
- Reset (any time, including mid-frame): o_Data_Valid=0, o_Data=0, o_Keys=0, o_Keys_Valid=0, o_Busy=0. State=IDLE, all counters 0. No partial frame is resumed.
- Latency: first push occurs 2 cycles after i_Enable is seen high in IDLE.

Test Plan:
- Full frame, FIFO never full: i_Segs=0x0706050403020100, i_Leds=0xA5, i_Bright=3, i_Disp_On=1 -> words 0x10040, 0x000C0, 0x00000, 0x00001, 0x00001, 0x00000 ... W17 0x10001, W18 0x1008B, W19 0x00042, W20..22 0x20000, W23 0x30000. Valid pulses are on alternate cycles only.
- Backpressure: hold i_FIFO_Full=1 for 10 cycles after W5 -> no pushes while full; W6 pushed intact after release; total 24 words, none duplicated or lost.
- Key read: return bytes 0x01, 0x10, 0x00, 0x11 on i_Rd_Valid -> o_Keys=0xA9, o_Keys_Valid single pulse, o_Busy falls the same cycle.
- Display off, KEY_SCAN=0: i_Disp_On=0 -> W18=0x10080; 19 words total; next frame starts REFRESH_CYCLES+1 cycles after W18 accept.
- Snapshot: change i_Segs after W3 -> the current frame carries old values; the next frame carries new values.
- Reset mid-frame at W10: all outputs 0 within the same cycle; after release with i_Enable=1, a fresh frame begins at W0=0x10040.

Source files
------------

// File: rtl/tm1638_frame_seq.sv
// TM1638 refresh-frame sequencer: turns a parallel display image into the spi_fifo
// word stream and assembles the key-scan bytes returned by the read transaction.
module tm1638_frame_seq #(
    parameter int REFRESH_CYCLES = 1000,
    parameter int KEY_SCAN       = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Enable,
    input  logic [63:0] i_Segs,
    input  logic [7:0]  i_Leds,
    input  logic [2:0]  i_Bright,
    input  logic        i_Disp_On,
    input  logic        i_FIFO_Full,
    output logic        o_Data_Valid,
    output logic [17:0] o_Data,
    input  logic        i_Rd_Valid,
    input  logic [7:0]  i_Rd_Data,
    output logic [7:0]  o_Keys,
    output logic        o_Keys_Valid,
    output logic        o_Busy
);
    localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(REFRESH_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CTRL,
        S_KEYCMD,
        S_KEYRD,
        S_WAITRD,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [1:0]       rd_cnt_q;
    logic             rd_done_q;
    logic [63:0]      segs_q;
    logic [7:0]       leds_q;
    logic [2:0]       bright_q;
    logic             disp_on_q;
    logic             full_q;
    logic             valid_q;
    logic [17:0]      data_q;
    logic [7:0]       keys_q;
    logic [7:0]       shadow_q;
    logic             keys_valid_q;
    logic             busy_q;

    logic [7:0]       data_byte [16];
    logic [17:0]      word_d;
    logic [7:0]       keys_d;
    logic             can_push;
    logic             rd_take;
    logic             rd_last;
    logic             unused_rd_bits;

    // Display RAM order: segment byte of digit k, then its LED byte.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign data_byte[2*gi]   = segs_q[8*gi +: 8];
        assign data_byte[2*gi+1] = {7'b0, leds_q[gi]};
    end

    // A push needs Full low for two consecutive cycles and never follows a push.
    assign can_push = !valid_q && !i_FIFO_Full && !full_q;
    assign rd_take  = i_Rd_Valid && (state_q == S_KEYRD || state_q == S_WAITRD);
    assign rd_last  = rd_take && (rd_cnt_q == 2'd3);
    assign unused_rd_bits = ^{i_Rd_Data[7:5], i_Rd_Data[3:1]};

    always_comb begin
        word_d = '0;
        case (state_q)
            S_CMD:    word_d = {2'b01, 8'h00, 8'h40};
            S_ADDR:   word_d = {2'b00, 8'h00, 8'hC0};
            S_DATA:   word_d = {1'b0, (idx_q == 4'd15), 8'h00, data_byte[idx_q]};
            S_CTRL:   word_d = {2'b01, 8'h00, disp_on_q ? {5'b10001, bright_q} : 8'h80};
            S_KEYCMD: word_d = {2'b00, 8'h00, 8'h42};
            S_KEYRD:  word_d = {1'b1, (idx_q[1:0] == 2'd3), 16'h0000};
            default:  word_d = '0;
        endcase
    end

    // Byte b of the scan carries key b in bit 0 and key b+4 in bit 4.
    always_comb begin
        keys_d = shadow_q;
        keys_d[{1'b0, rd_cnt_q}] = i_Rd_Data[0];
        keys_d[{1'b1, rd_cnt_q}] = i_Rd_Data[4];
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            segs_q       <= '0;
            leds_q       <= '0;
            bright_q     <= '0;
            disp_on_q    <= 1'b0;
            full_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            keys_q       <= '0;
            shadow_q     <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            full_q       <= i_FIFO_Full;
            valid_q      <= 1'b0;
            keys_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (i_Enable && gap_cnt_q == '0) begin
                        segs_q    <= i_Segs;
                        leds_q    <= i_Leds;
                        bright_q  <= i_Bright;
                        disp_on_q <= i_Disp_On;
                        idx_q     <= '0;
                        rd_cnt_q  <= '0;
                        rd_done_q <= 1'b0;
                        shadow_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        idx_q   <= idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_q <= S_CTRL;
                        end
                    end
                end
                S_CTRL: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        if (KEY_SCAN != 0) begin
                            state_q <= S_KEYCMD;
                        end else begin
                            busy_q    <= 1'b0;
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_KEYCMD: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        idx_q   <= '0;
                        state_q <= S_KEYRD;
                    end
                end
                S_KEYRD: begin
                    if (can_push) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        idx_q   <= idx_q + 4'd1;
                        if (idx_q[1:0] == 2'd3) begin
                            state_q <= S_WAITRD;
                        end
                    end
                end
                S_WAITRD: begin
                    if (rd_done_q || rd_last) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q <= CNT_W'(1)) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (rd_take) begin
                rd_cnt_q <= rd_cnt_q + 2'd1;
                if (rd_last) begin
                    keys_q       <= keys_d;
                    keys_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    rd_done_q    <= 1'b1;
                end else begin
                    shadow_q <= keys_d;
                end
            end
        end
    end

    assign o_Data_Valid = valid_q;
    assign o_Data       = data_q;
    assign o_Keys       = keys_q;
    assign o_Keys_Valid = keys_valid_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Bench for tm1638_frame_seq: a key-scanning instance and a write-only instance are
// driven with random images and checked against a frame/key model built from the word rules.
`timescale 1ns/1ps
module tb_tm1638_frame_seq;
    localparam int R = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic        rst = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [63:0] a_segs = '0, b_segs = '0;
    logic [7:0]  a_leds = '0, b_leds = '0;
    logic [2:0]  a_br = '0, b_br = '0;
    logic        a_on = 1'b0, b_on = 1'b0;
    logic        a_full = 1'b0, b_full = 1'b0;
    logic        a_rd_valid = 1'b0, b_rd_valid = 1'b0;
    logic [7:0]  a_rd_data = '0, b_rd_data = '0;
    logic        a_valid, b_valid;
    logic [17:0] a_data, b_data;
    logic [7:0]  a_keys, b_keys;
    logic        a_kv, b_kv;
    logic        a_busy, b_busy;

    tm1638_frame_seq #(.REFRESH_CYCLES(R), .KEY_SCAN(1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(a_en), .i_Segs(a_segs), .i_Leds(a_leds),
        .i_Bright(a_br), .i_Disp_On(a_on), .i_FIFO_Full(a_full),
        .o_Data_Valid(a_valid), .o_Data(a_data), .i_Rd_Valid(a_rd_valid), .i_Rd_Data(a_rd_data),
        .o_Keys(a_keys), .o_Keys_Valid(a_kv), .o_Busy(a_busy)
    );

    tm1638_frame_seq #(.REFRESH_CYCLES(R), .KEY_SCAN(0)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(b_en), .i_Segs(b_segs), .i_Leds(b_leds),
        .i_Bright(b_br), .i_Disp_On(b_on), .i_FIFO_Full(b_full),
        .o_Data_Valid(b_valid), .o_Data(b_data), .i_Rd_Valid(b_rd_valid), .i_Rd_Data(b_rd_data),
        .o_Keys(b_keys), .o_Keys_Valid(b_kv), .o_Busy(b_busy)
    );

    // Observed traffic, sampled mid-cycle.
    logic [17:0] a_words[$];
    int          a_cycles[$];
    logic [17:0] b_words[$];
    int          b_cycles[$];
    int          b_rise[$];
    int          a_viol = 0, b_viol = 0;
    int          kv_count = 0, b_kv_count = 0;
    logic [7:0]  kv_keys = '0;
    logic        kv_busy = 1'b0, kv_busy_p = 1'b0;
    logic        a_valid_p = 1'b0, a_full_p = 1'b0, a_busy_p = 1'b0, a_kv_p = 1'b0;
    logic        b_valid_p = 1'b0, b_full_p = 1'b0, b_busy_p = 1'b0;

    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            a_words.push_back(a_data);
            a_cycles.push_back(cyc);
            if (a_valid_p || a_full_p) a_viol++;
        end
        if (a_kv === 1'b1) begin
            kv_count++;
            kv_keys   = a_keys;
            kv_busy   = a_busy;
            kv_busy_p = a_busy_p;
            if (a_kv_p) a_viol++;
        end
        if (b_valid === 1'b1) begin
            b_words.push_back(b_data);
            b_cycles.push_back(cyc);
            if (b_valid_p || b_full_p) b_viol++;
        end
        if (b_kv === 1'b1) b_kv_count++;
        if (b_busy === 1'b1 && !b_busy_p) b_rise.push_back(cyc);
        a_valid_p = a_valid; a_full_p = a_full; a_busy_p = a_busy; a_kv_p = a_kv;
        b_valid_p = b_valid; b_full_p = b_full; b_busy_p = b_busy;
    end

    // Reference model: the frame as a list of words, keys from the scan bytes.
    logic [17:0] exp_q[$];

    task automatic build_expected(input logic [63:0] segs, input logic [7:0] leds,
                                  input logic [2:0] br, input logic on, input bit ks);
        exp_q.delete();
        exp_q.push_back(18'h10040);
        exp_q.push_back(18'h000C0);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({10'h000, segs[8*k +: 8]});
            exp_q.push_back((k == 7 ? 18'h10000 : 18'h00000) + 18'(leds[k]));
        end
        exp_q.push_back(on ? 18'h10088 + 18'(br) : 18'h10080);
        if (ks) begin
            exp_q.push_back(18'h00042);
            for (int r = 0; r < 3; r++) exp_q.push_back(18'h20000);
            exp_q.push_back(18'h30000);
        end
    endtask

    function automatic logic [7:0] keys_model(input logic [31:0] rb);
        logic [7:0] k;
        k = '0;
        for (int b = 0; b < 4; b++) begin
            k[b]     = rb[8*b];
            k[b + 4] = rb[8*b + 4];
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_a_words(input int n, input int limit, output bit ok);
        for (int i = 0; i < limit && a_words.size() < n; i++) tick();
        ok = (a_words.size() >= n);
    endtask

    task automatic wait_b_words(input int n, input int limit, output bit ok);
        for (int i = 0; i < limit && b_words.size() < n; i++) tick();
        ok = (b_words.size() >= n);
    endtask

    task automatic wait_a_busy(input int limit, output bit ok);
        for (int i = 0; i < limit && a_busy !== 1'b1; i++) tick();
        ok = (a_busy === 1'b1);
    endtask

    task automatic wait_kv(input int n, input int limit, output bit ok);
        for (int i = 0; i < limit && kv_count < n; i++) tick();
        ok = (kv_count >= n);
    endtask

    task automatic send_reads_a(input logic [31:0] rb);
        for (int b = 0; b < 4; b++) begin
            tick();
            a_rd_valid = 1'b1;
            a_rd_data  = rb[8*b +: 8];
            tick();
            a_rd_valid = 1'b0;
            a_rd_data  = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({a_valid, a_data, a_keys, a_kv, a_busy} !== 30'h0) begin
            n_err++;
            $display("FAIL reset_a: outputs %08h required 0", {a_valid, a_data, a_keys, a_kv, a_busy});
        end
        n_cmp++;
        if ({b_valid, b_data, b_keys, b_kv, b_busy} !== 30'h0) begin
            n_err++;
            $display("FAIL reset_b: outputs %08h required 0", {b_valid, b_data, b_keys, b_kv, b_busy});
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_full_frame();
        int base, kv0, en_cyc, bad;
        bit ok;
        logic [31:0] rb;
        rb = 32'h11001001;
        base = a_words.size();
        kv0 = kv_count;
        a_segs = 64'h0706050403020100; a_leds = 8'hA5; a_br = 3'd3; a_on = 1'b1;
        build_expected(a_segs, a_leds, a_br, a_on, 1'b1);
        a_en = 1'b1;
        en_cyc = cyc;
        wait_a_busy(10, ok);
        a_en = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL full_frame busy_rise: busy=%0b required 1", a_busy); end
        wait_a_words(base + 24, 300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL full_frame word_count: got %0d required 24", a_words.size() - base); end
        if (ok) begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL full_frame W%0d: got %05h required %05h", i, a_words[base + i], exp_q[i]);
                end
            end
            n_cmp++;
            if (a_cycles[base] !== en_cyc + 2) begin
                n_err++;
                $display("FAIL full_frame latency: first push cycle %0d required %0d", a_cycles[base], en_cyc + 2);
            end
            bad = 0;
            for (int i = 0; i < 23; i++) if (a_cycles[base + i + 1] - a_cycles[base + i] != 2) bad++;
            n_cmp++;
            if (bad !== 0) begin n_err++; $display("FAIL full_frame spacing: %0d gaps not 2 cycles, required 0", bad); end
        end
        send_reads_a(rb);
        wait_kv(kv0 + 1, 20, ok);
        tick(); tick(); tick();
        n_cmp++;
        if (kv_count !== kv0 + 1) begin n_err++; $display("FAIL full_frame keys_valid_pulses: got %0d required 1", kv_count - kv0); end
        n_cmp++;
        if (kv_keys !== keys_model(rb) || a_keys !== 8'hA9) begin
            n_err++;
            $display("FAIL full_frame keys: got %02h/%02h required %02h", kv_keys, a_keys, keys_model(rb));
        end
        n_cmp++;
        if (kv_busy !== 1'b0 || kv_busy_p !== 1'b1) begin
            n_err++;
            $display("FAIL full_frame busy_fall: busy at pulse %0b (before %0b) required 0 (1)", kv_busy, kv_busy_p);
        end
        $display("full_frame: %0d words, keys %02h", a_words.size() - base, a_keys);
    endtask

    task automatic test_backpressure();
        int base, kv0, sz;
        bit ok;
        logic [31:0] rb;
        rb = $urandom;
        base = a_words.size();
        kv0 = kv_count;
        a_segs = {$urandom, $urandom}; a_leds = 8'($urandom); a_br = 3'($urandom); a_on = 1'b1;
        build_expected(a_segs, a_leds, a_br, a_on, 1'b1);
        a_en = 1'b1;
        wait_a_busy(R + 50, ok);
        a_en = 1'b0;
        wait_a_words(base + 6, 100, ok);
        a_full = 1'b1;
        sz = a_words.size();
        repeat (10) tick();
        n_cmp++;
        if (a_words.size() !== sz) begin n_err++; $display("FAIL backpressure stall: %0d pushes while full, required 0", a_words.size() - sz); end
        a_full = 1'b0;
        wait_a_words(base + 24, 300, ok);
        send_reads_a(rb);
        wait_kv(kv0 + 1, 20, ok);
        repeat (4) tick();
        n_cmp++;
        if (a_words.size() !== base + 24) begin n_err++; $display("FAIL backpressure count: got %0d words required 24", a_words.size() - base); end
        if (a_words.size() >= base + 24) begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL backpressure W%0d: got %05h required %05h", i, a_words[base + i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (a_keys !== keys_model(rb)) begin n_err++; $display("FAIL backpressure keys: got %02h required %02h", a_keys, keys_model(rb)); end
        n_cmp++;
        if (a_viol !== 0) begin n_err++; $display("FAIL backpressure push_rule: %0d violations required 0", a_viol); end
        $display("backpressure: %0d words after 10-cycle stall", a_words.size() - base);
    endtask

    task automatic test_random_backpressure();
        int base, kv0;
        bit ok, spur;
        logic [31:0] rb;
        rb = $urandom;
        spur = 1'b0;
        base = a_words.size();
        kv0 = kv_count;
        a_segs = {$urandom, $urandom}; a_leds = 8'($urandom); a_br = 3'($urandom); a_on = 1'($urandom);
        build_expected(a_segs, a_leds, a_br, a_on, 1'b1);
        a_en = 1'b1;
        wait_a_busy(R + 50, ok);
        a_en = 1'b0;
        for (int i = 0; i < 3000 && a_words.size() < base + 24; i++) begin
            tick();
            a_full = ($urandom_range(0, 9) < 3);
            a_rd_valid = 1'b0;
            if (!spur && a_words.size() >= base + 6) begin
                a_rd_valid = 1'b1;
                a_rd_data  = 8'hFF;
                spur = 1'b1;
            end
        end
        a_full = 1'b0;
        a_rd_valid = 1'b0;
        n_cmp++;
        if (a_words.size() < base + 24) begin n_err++; $display("FAIL random_bp timeout: got %0d words required 24", a_words.size() - base); end
        send_reads_a(rb);
        wait_kv(kv0 + 1, 20, ok);
        repeat (4) tick();
        if (a_words.size() >= base + 24) begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL random_bp W%0d: got %05h required %05h", i, a_words[base + i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (kv_count !== kv0 + 1 || a_keys !== keys_model(rb)) begin
            n_err++;
            $display("FAIL random_bp keys: got %02h (%0d pulses) required %02h (1 pulse)", a_keys, kv_count - kv0, keys_model(rb));
        end
        n_cmp++;
        if (a_viol !== 0) begin n_err++; $display("FAIL random_bp push_rule: %0d violations required 0", a_viol); end
        $display("random_bp: frame of %0d words, keys %02h", a_words.size() - base, a_keys);
    endtask

    task automatic test_snapshot();
        int base, kv0;
        bit ok;
        logic [31:0] rb1, rb2;
        logic [63:0] s1, s2;
        logic [7:0]  l1, l2;
        logic [2:0]  br1, br2;
        rb1 = $urandom; rb2 = $urandom;
        s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
        l1 = 8'($urandom); l2 = 8'($urandom);
        br1 = 3'($urandom); br2 = 3'($urandom);
        base = a_words.size();
        kv0 = kv_count;
        a_segs = s1; a_leds = l1; a_br = br1; a_on = 1'b1;
        a_en = 1'b1;
        wait_a_busy(R + 50, ok);
        wait_a_words(base + 4, 100, ok);
        a_segs = s2; a_leds = l2; a_br = br2;
        wait_a_words(base + 24, 300, ok);
        send_reads_a(rb1);
        wait_kv(kv0 + 1, 20, ok);
        wait_a_words(base + 25, R + 100, ok);
        a_en = 1'b0;
        wait_a_words(base + 48, 300, ok);
        send_reads_a(rb2);
        wait_kv(kv0 + 2, 20, ok);
        n_cmp++;
        if (a_words.size() < base + 48) begin n_err++; $display("FAIL snapshot count: got %0d words required 48", a_words.size() - base); end
        if (a_words.size() >= base + 48) begin
            build_expected(s1, l1, br1, 1'b1, 1'b1);
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL snapshot frame1 W%0d: got %05h required %05h", i, a_words[base + i], exp_q[i]);
                end
            end
            build_expected(s2, l2, br2, 1'b1, 1'b1);
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base + 24 + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL snapshot frame2 W%0d: got %05h required %05h", i, a_words[base + 24 + i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (a_keys !== keys_model(rb2)) begin n_err++; $display("FAIL snapshot keys: got %02h required %02h", a_keys, keys_model(rb2)); end
        $display("snapshot: two frames, %0d words", a_words.size() - base);
    endtask

    task automatic test_display_off();
        int base, rbase;
        bit ok;
        base = b_words.size();
        rbase = b_rise.size();
        b_segs = {$urandom, $urandom}; b_leds = 8'($urandom); b_br = 3'($urandom); b_on = 1'b0;
        build_expected(b_segs, b_leds, b_br, b_on, 1'b0);
        b_en = 1'b1;
        wait_b_words(base + 19, 300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL disp_off count: got %0d words required 19", b_words.size() - base); end
        if (ok) begin
            for (int i = 0; i < 19; i++) begin
                n_cmp++;
                if (b_words[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL disp_off W%0d: got %05h required %05h", i, b_words[base + i], exp_q[i]);
                end
            end
            n_cmp++;
            if (b_words[base + 18] !== 18'h10080) begin n_err++; $display("FAIL disp_off W18: got %05h required 10080", b_words[base + 18]); end
        end
        for (int i = 0; i < R + 50 && b_rise.size() < rbase + 2; i++) tick();
        b_en = 1'b0;
        n_cmp++;
        if (b_rise.size() < rbase + 2 || b_words.size() < base + 19) begin
            n_err++;
            $display("FAIL disp_off refresh: next frame did not start");
        end else if (b_rise[rbase + 1] !== b_cycles[base + 18] + R + 1) begin
            n_err++;
            $display("FAIL disp_off refresh: frame start %0d cycles after W18, required %0d",
                     b_rise[rbase + 1] - b_cycles[base + 18], R + 1);
        end
        wait_b_words(base + 38, 300, ok);
        repeat (4) tick();
        n_cmp++;
        if (b_words.size() !== base + 38 || b_words[base + 19] !== 18'h10040) begin
            n_err++;
            $display("FAIL disp_off frame2: %0d words required 38", b_words.size() - base);
        end
        n_cmp++;
        if (b_kv_count !== 0 || b_keys !== 8'h00 || b_viol !== 0) begin
            n_err++;
            $display("FAIL disp_off misc: kv=%0d keys=%02h viol=%0d required 0/00/0", b_kv_count, b_keys, b_viol);
        end
        $display("disp_off: %0d words over two frames", b_words.size() - base);
    endtask

    task automatic test_reset_mid_frame();
        int base, base2, kv0;
        bit ok;
        logic [31:0] rb;
        rb = $urandom;
        base = a_words.size();
        a_segs = {$urandom, $urandom}; a_leds = 8'($urandom); a_br = 3'($urandom); a_on = 1'b1;
        build_expected(a_segs, a_leds, a_br, a_on, 1'b1);
        a_en = 1'b1;
        wait_a_busy(R + 50, ok);
        wait_a_words(base + 11, 100, ok);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_valid, a_data, a_keys, a_kv, a_busy} !== 30'h0) begin
            n_err++;
            $display("FAIL reset_mid immediate: outputs %08h required 0", {a_valid, a_data, a_keys, a_kv, a_busy});
        end
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (a_words.size() !== base + 11) begin n_err++; $display("FAIL reset_mid partial: %0d words required 11", a_words.size() - base); end
        base2 = a_words.size();
        kv0 = kv_count;
        wait_a_busy(20, ok);
        a_en = 1'b0;
        wait_a_words(base2 + 24, 300, ok);
        send_reads_a(rb);
        wait_kv(kv0 + 1, 20, ok);
        n_cmp++;
        if (a_words.size() < base2 + 24) begin n_err++; $display("FAIL reset_mid count: got %0d words required 24", a_words.size() - base2); end
        if (a_words.size() >= base2 + 24) begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (a_words[base2 + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL reset_mid W%0d: got %05h required %05h", i, a_words[base2 + i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (a_keys !== keys_model(rb)) begin n_err++; $display("FAIL reset_mid keys: got %02h required %02h", a_keys, keys_model(rb)); end
        $display("reset_mid: fresh frame of %0d words after reset", a_words.size() - base2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        for (int r = 0; r < 3; r++) test_random_backpressure();
        test_snapshot();
        test_display_off();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
